// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - pitch codes, note frequency table, half-period helper, FSM encoding
//
// Shared by the melody ROM and the sequencer top. No ports.
//  PC_*            4-bit pitch codes as stored in ROM word bits [7:4]
//  note_freq_mhz   note frequency in millihertz (0 for rest/reserved/end)
//  half_period_of  clk_hz / (2 * f_note), truncated; 0 for silent codes
//  state_t         sequencer FSM states
package buzzer_pkg;

  localparam logic [3:0] PC_REST = 4'd0;
  localparam logic [3:0] PC_C4   = 4'd1;
  localparam logic [3:0] PC_CS4  = 4'd2;
  localparam logic [3:0] PC_D4   = 4'd3;
  localparam logic [3:0] PC_DS4  = 4'd4;
  localparam logic [3:0] PC_E4   = 4'd5;
  localparam logic [3:0] PC_F4   = 4'd6;
  localparam logic [3:0] PC_FS4  = 4'd7;
  localparam logic [3:0] PC_G4   = 4'd8;
  localparam logic [3:0] PC_GS4  = 4'd9;
  localparam logic [3:0] PC_A4   = 4'd10;
  localparam logic [3:0] PC_AS4  = 4'd11;
  localparam logic [3:0] PC_B4   = 4'd12;
  localparam logic [3:0] PC_C5   = 4'd13;
  localparam logic [3:0] PC_RSVD = 4'd14;
  localparam logic [3:0] PC_END  = 4'd15;

  localparam int unsigned HP_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  // Millihertz keeps the truncated half-periods exact without reals.
  function automatic logic [31:0] note_freq_mhz(input logic [3:0] pc);
    case (pc)
      PC_C4:   return 32'd261626;
      PC_CS4:  return 32'd277183;
      PC_D4:   return 32'd293665;
      PC_DS4:  return 32'd311127;
      PC_E4:   return 32'd329628;
      PC_F4:   return 32'd349228;
      PC_FS4:  return 32'd369994;
      PC_G4:   return 32'd391995;
      PC_GS4:  return 32'd415305;
      PC_A4:   return 32'd440000;
      PC_AS4:  return 32'd466164;
      PC_B4:   return 32'd493883;
      PC_C5:   return 32'd523251;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] half_period_of(input logic [63:0] clk_hz, input logic [3:0] pc);
    logic [63:0] f;
    f = {32'd0, note_freq_mhz(pc)};
    if (f == 64'd0) return 32'd0;
    return 32'((clk_hz * 64'd1000) / (64'd2 * f));
  endfunction

endpackage

// File: rtl/buzzer_melody_rom.sv
// rtl/buzzer_melody_rom.sv - case-based melody ROM with registered output
//
// Ports:
//  clk   in   1       system clock
//  addr  in   ADDR_W  note index
//  data  out  8       {pitch code, beats-1}, valid one clock after addr
// ROM_SEL selects the melody: 0 = production tune, 1 = short test tune.
module buzzer_melody_rom
  import buzzer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned ROM_SEL = 0
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  function automatic logic [7:0] rom_word(input int unsigned sel, input int unsigned a);
    if (sel == 1) begin
      case (a)
        0:       return {PC_C4, 4'd0};
        1:       return {PC_A4, 4'd1};
        2:       return {PC_REST, 4'd2};
        default: return {PC_END, 4'd0};
      endcase
    end
    case (a)
      0:       return {PC_C4, 4'd0};
      1:       return {PC_C4, 4'd0};
      2:       return {PC_G4, 4'd0};
      3:       return {PC_G4, 4'd0};
      4:       return {PC_A4, 4'd0};
      5:       return {PC_A4, 4'd0};
      6:       return {PC_G4, 4'd1};
      7:       return {PC_F4, 4'd0};
      8:       return {PC_F4, 4'd0};
      9:       return {PC_E4, 4'd0};
      10:      return {PC_E4, 4'd0};
      11:      return {PC_D4, 4'd0};
      12:      return {PC_D4, 4'd0};
      13:      return {PC_C4, 4'd1};
      14:      return {PC_REST, 4'd0};
      default: return {PC_END, 4'd0};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    data <= rom_word(ROM_SEL, 32'(addr));
  end

endmodule

// File: rtl/buzzer_melody_seq.sv
// rtl/buzzer_melody_seq.sv - melody sequencer feeding the buzzer square-wave stage
//
// Ports:
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous active-low reset
//  start        in   1    pulse; starts playback at note 0 when idle
//  stop         in   1    pulse; aborts playback (wins over start)
//  loop         in   1    level; at end of melody 1 = restart, 0 = done
//  half_period  out  20   clocks per half cycle of current pitch, 0 when silent
//  tone_on      out  1    downstream stage toggles the pin while high
//  busy         out  1    high in every state except IDLE
//  done         out  1    one-cycle pulse when a one-shot melody completes
//  note_idx     out  IW   note being fetched or played
module buzzer_melody_seq
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int unsigned NOTES       = 16,
  parameter int unsigned ROM_SEL     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [HP_W-1:0]          half_period,
  output logic                     tone_on,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] note_idx
);

  localparam int unsigned IDX_W   = $clog2(NOTES);
  localparam int unsigned CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NOTES - 1);

  if (BEAT_CYCLES < 2) begin : g_beat_check
    $error("BEAT_CYCLES must be at least 2");
  end
  if (GAP_CYCLES < 1) begin : g_gap_check
    $error("GAP_CYCLES must be at least 1");
  end

  // Pitch lookup is folded to constants; each entry is range-checked here.
  logic [HP_W-1:0] hp_lut [16];
  for (genvar p = 0; p < 16; p++) begin : g_hp
    localparam logic [31:0] HP = half_period_of(64'(CLK_HZ), 4'(p));
    if (HP > 32'h000F_FFFF) begin : g_hp_check
      $error("half-period does not fit in 20 bits");
    end
    assign hp_lut[p] = HP[HP_W-1:0];
  end

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [3:0]       beats_left;
  logic [7:0]       rom_data;
  logic [3:0]       rom_pitch;
  logic [3:0]       rom_beats;

  assign rom_pitch = rom_data[7:4];
  assign rom_beats = rom_data[3:0];

  buzzer_melody_rom #(
    .ADDR_W (IDX_W),
    .ROM_SEL(ROM_SEL)
  ) u_rom (
    .clk (clk),
    .addr(note_idx),
    .data(rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      half_period <= '0;
      tone_on     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      note_idx    <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      beats_left  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state       <= ST_IDLE;
        half_period <= '0;
        tone_on     <= 1'b0;
        busy        <= 1'b0;
        beat_cnt    <= '0;
        gap_cnt     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_FETCH;
              note_idx <= '0;
              busy     <= 1'b1;
              beat_cnt <= '0;
              gap_cnt  <= '0;
            end
          end
          // ROM samples note_idx on this edge; data is ready in LOAD.
          ST_FETCH: state <= ST_LOAD;
          ST_LOAD: begin
            if (rom_pitch == PC_END) begin
              if (loop) begin
                note_idx <= '0;
                state    <= ST_FETCH;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              half_period <= hp_lut[rom_pitch];
              tone_on     <= (rom_pitch != PC_REST) && (rom_pitch != PC_RSVD);
              beats_left  <= rom_beats;
              beat_cnt    <= '0;
              state       <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (beats_left == 4'd0) begin
                state       <= ST_GAP;
                tone_on     <= 1'b0;
                half_period <= '0;
                gap_cnt     <= '0;
              end else begin
                beats_left <= beats_left - 4'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              // Last ROM slot played: same end-of-melody rule as the end marker.
              if (note_idx == IDX_LAST) begin
                if (loop) begin
                  note_idx <= '0;
                  state    <= ST_FETCH;
                end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end else begin
                note_idx <= note_idx + IDX_W'(1);
                state    <= ST_FETCH;
              end
            end else begin
              gap_cnt <= gap_cnt + CNT_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_melody_seq.sv
// tb/tb_buzzer_melody_seq.sv - scoreboard bench for buzzer_melody_seq
module tb_buzzer_melody_seq;

  localparam int BEAT     = 10;
  localparam int GAP      = 2;
  localparam int NOTES    = 16;
  localparam int PLAN_CAP = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [19:0] half_period;
  logic        tone_on;
  logic        busy;
  logic        done;
  logic [3:0]  note_idx;

  buzzer_melody_seq #(
    .CLK_HZ     (50_000_000),
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES (GAP),
    .NOTES      (NOTES),
    .ROM_SEL    (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .half_period(half_period),
    .tone_on    (tone_on),
    .busy       (busy),
    .done       (done),
    .note_idx   (note_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    bit tone;
    int hp;
    bit done;
    int idx;
    bit chk_idx;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       plan[$];
  exp_t       cur;
  exp_t       idle_e;
  logic [7:0] melody [NOTES];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 0;

  function automatic exp_t mk(bit b, bit t, int hp, bit d, int idx, bit ci);
    exp_t e;
    e.busy = b; e.tone = t; e.hp = hp; e.done = d; e.idx = idx; e.chk_idx = ci;
    return e;
  endfunction

  // Equal-tempered pitch from A4 = 440 Hz, half-period truncated.
  function automatic int ref_hp(input int pc);
    real f;
    if (pc < 1 || pc > 13) return 0;
    f = 440.0 * (2.0 ** ((pc - 10) / 12.0));
    return $rtoi(50.0e6 / (2.0 * f));
  endfunction

  // Whole expected output trace for one accepted start, from the cycle after it.
  task automatic build_plan(input bit lp);
    int idx, pc, nb;
    logic [7:0] w;
    bit fin;
    plan.delete();
    idx = 0;
    fin = 0;
    repeat (2) plan.push_back(mk(1, 0, 0, 0, idx, 1));
    while (!fin && plan.size() < PLAN_CAP) begin
      w  = melody[idx];
      pc = int'(w[7:4]);
      nb = int'(w[3:0]) + 1;
      if (pc != 15) begin
        repeat (nb * BEAT) plan.push_back(mk(1, (pc >= 1 && pc <= 13), ref_hp(pc), 0, idx, 1));
        repeat (GAP) plan.push_back(mk(1, 0, 0, 0, idx, 1));
      end
      if (pc == 15 || idx == NOTES - 1) begin
        if (lp) idx = 0;
        else begin
          plan.push_back(mk(1, 0, 0, 1, idx, 1));
          fin = 1;
        end
      end else begin
        idx++;
      end
      if (!fin) repeat (2) plan.push_back(mk(1, 0, 0, 0, idx, 1));
    end
  endtask

  task automatic model_step(input bit s, input bit p);
    exp_t nxt;
    if (p) begin
      plan.delete();
      nxt = idle_e;
    end else if (!cur.busy && s) begin
      build_plan(loop);
      nxt = plan.pop_front();
    end else if (plan.size() > 0) begin
      nxt = plan.pop_front();
    end else begin
      nxt = idle_e;
    end
    exp_q.push_back(nxt);
    cur = nxt;
  endtask

  task automatic step(input bit s, input bit p);
    start = s;
    stop  = p;
    model_step(s, p);
    @(posedge clk);
    #1;
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
    exp_q.delete();
    plan.delete();
    start = 1'b0;
    stop  = 1'b0;
    cur   = idle_e;
    exp_q.push_back(cur);
    mon_en = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (busy !== e.busy || tone_on !== e.tone || half_period !== 20'(e.hp) ||
            done !== e.done || (e.chk_idx && note_idx !== 4'(e.idx))) begin
          errors++;
          $display("FAIL cycle_outputs at %0t: got busy=%0b tone_on=%0b half_period=%0d done=%0b note_idx=%0d, expected busy=%0b tone_on=%0b half_period=%0d done=%0b note_idx=%0d",
                   $time, busy, tone_on, half_period, done, note_idx,
                   e.busy, e.tone, e.hp, e.done, e.idx);
        end
      end
    end
  end

  initial begin
    bit s, p;
    idle_e = mk(0, 0, 0, 0, 0, 0);
    cur = idle_e;
    for (int i = 0; i < NOTES; i++) melody[i] = 8'hF0;
    melody[0] = 8'h10;
    melody[1] = 8'hA1;
    melody[2] = 8'h02;

    #23;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_tone_on", 32'(tone_on), 0);
    chk("reset_half_period", 32'(half_period), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_note_idx", 32'(note_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    resync();

    // Idle with no start.
    repeat (100) step(0, 0);

    // One-shot melody: C4, A4, rest, end marker, done pulse.
    loop = 1'b0;
    step(1, 0);
    repeat (100) step(0, 0);

    // Looped melody, then stop.
    loop = 1'b1;
    step(1, 0);
    repeat (160) step(0, 0);
    step(0, 1);
    repeat (5) step(0, 0);
    loop = 1'b0;

    // Stop in the middle of A4, then replay from note 0.
    step(1, 0);
    repeat (25) step(0, 0);
    step(0, 1);
    repeat (5) step(0, 0);
    step(1, 0);
    repeat (90) step(0, 0);

    // Start with stop while idle; start while playing.
    step(1, 1);
    repeat (5) step(0, 0);
    step(1, 0);
    repeat (30) step(0, 0);
    step(1, 0);
    repeat (60) step(0, 0);

    // Random start/stop/loop traffic.
    repeat (1500) begin
      if (!cur.busy && $urandom_range(0, 3) == 0) loop = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 15) == 0);
      p = ($urandom_range(0, 79) == 0);
      if (loop && cur.busy && plan.size() < 10) p = 1'b1;
      step(s, p);
    end
    loop = 1'b0;
    repeat (5) step(0, 1);

    // Asynchronous reset in the middle of C4.
    step(1, 0);
    repeat (5) step(0, 0);
    #2;
    chk("pre_reset_tone_on", 32'(tone_on), 1);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_tone_on", 32'(tone_on), 0);
    chk("async_half_period", 32'(half_period), 0);
    chk("async_done", 32'(done), 0);
    chk("async_note_idx", 32'(note_idx), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    resync();
    repeat (20) step(0, 0);
    step(1, 0);
    repeat (90) step(0, 0);

    @(negedge clk);
    #1;
    mon_en = 0;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
